// File: rtl/fetch_control.sv
// LC-3 fetch-phase controller: PC->MAR, timed memory read into MDR, MDR->IR,
// then a Continue press/release handshake before the next fetch.
module fetch_control #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_ah,
    input  logic       Run,
    input  logic       Continue,
    output logic       LD_PC,
    output logic       LD_IR,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        HALTED = 4'd0,
        S18    = 4'd1,
        S33    = 4'd2,
        S35    = 4'd3,
        PAUSE1 = 4'd4,
        PAUSE2 = 4'd5
    } state_t;

    localparam logic [3:0] WAIT_C = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       read_done;

    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            state_q <= HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter never passes WAIT_C, so equality marks the final read cycle.
    assign read_done = (cnt_q == WAIT_C);

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        LD_PC      = 1'b0;
        LD_IR      = 1'b0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        case (state_q)
            HALTED: begin
                if (Run) state_d = S18;
            end
            S18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                PCMUX   = 2'b10;
                state_d = S33;
            end
            S33: begin
                Mem_OE = 1'b0;
                if (read_done) begin
                    LD_MDR  = 1'b1;
                    state_d = S35;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = PAUSE1;
            end
            PAUSE1: begin
                if (Continue) state_d = PAUSE2;
            end
            PAUSE2: begin
                if (!Continue) state_d = S18;
            end
            default: state_d = HALTED;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: one DUT with MEM_WAIT=2, one with MEM_WAIT=0.
module tb_fetch_control;

    // Packed view: {State, LD_PC LD_IR LD_MAR LD_MDR, GatePC GateMDR GateALU GateMARMUX,
    //               PCMUX ADDR2MUX ALUK, Mem_OE Mem_WE}
    localparam logic [19:0] O_HALT = 20'b0000_0000_0000_000000_11;
    localparam logic [19:0] O_S18  = 20'b0001_1010_1000_100000_11;
    localparam logic [19:0] O_S33  = 20'b0010_0000_0000_000000_01;
    localparam logic [19:0] O_S33L = 20'b0010_0001_0000_000000_01;
    localparam logic [19:0] O_S35  = 20'b0011_0100_0100_000000_11;
    localparam logic [19:0] O_P1   = 20'b0100_0000_0000_000000_11;
    localparam logic [19:0] O_P2   = 20'b0101_0000_0000_000000_11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // MEM_WAIT = 2 instance
    logic       rst2 = 1'b0, run2 = 1'b0, cont2 = 1'b0;
    logic       ld_pc, ld_ir, ld_mar, ld_mdr, g_pc, g_mdr, g_alu, g_marmux, oe, we;
    logic [1:0] pcmux, addr2mux, aluk;
    logic [3:0] st;
    logic [19:0] o2;

    // MEM_WAIT = 0 instance
    logic       rst0 = 1'b0, run0 = 1'b0, cont0 = 1'b0;
    logic       z_ld_pc, z_ld_ir, z_ld_mar, z_ld_mdr, z_g_pc, z_g_mdr, z_g_alu, z_g_marmux, z_oe, z_we;
    logic [1:0] z_pcmux, z_addr2mux, z_aluk;
    logic [3:0] z_st;
    logic [19:0] o0;

    fetch_control #(.MEM_WAIT(2)) dut (
        .Clk(clk), .Reset_ah(rst2), .Run(run2), .Continue(cont2),
        .LD_PC(ld_pc), .LD_IR(ld_ir), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
        .GatePC(g_pc), .GateMDR(g_mdr), .GateALU(g_alu), .GateMARMUX(g_marmux),
        .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
        .Mem_OE(oe), .Mem_WE(we), .State(st)
    );

    fetch_control #(.MEM_WAIT(0)) dut0 (
        .Clk(clk), .Reset_ah(rst0), .Run(run0), .Continue(cont0),
        .LD_PC(z_ld_pc), .LD_IR(z_ld_ir), .LD_MAR(z_ld_mar), .LD_MDR(z_ld_mdr),
        .GatePC(z_g_pc), .GateMDR(z_g_mdr), .GateALU(z_g_alu), .GateMARMUX(z_g_marmux),
        .PCMUX(z_pcmux), .ADDR2MUX(z_addr2mux), .ALUK(z_aluk),
        .Mem_OE(z_oe), .Mem_WE(z_we), .State(z_st)
    );

    assign o2 = {st, ld_pc, ld_ir, ld_mar, ld_mdr, g_pc, g_mdr, g_alu, g_marmux,
                 pcmux, addr2mux, aluk, oe, we};
    assign o0 = {z_st, z_ld_pc, z_ld_ir, z_ld_mar, z_ld_mdr, z_g_pc, z_g_mdr, z_g_alu, z_g_marmux,
                 z_pcmux, z_addr2mux, z_aluk, z_oe, z_we};

    // Advance one clock and settle past the edge; inputs set after this are sampled next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (o2 !== O_HALT) begin
                n_err++; $display("FAIL reset[%0d] got %b want %b", i, o2, O_HALT);
            end
            n_cmp++;
            if (o0 !== O_HALT) begin
                n_err++; $display("FAIL reset0[%0d] got %b want %b", i, o0, O_HALT);
            end
        end
        rst2 = 1'b0; rst0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (o2 !== O_HALT) begin
                n_err++; $display("FAIL idle[%0d] got %b want %b", i, o2, O_HALT);
            end
        end
    endtask

    task automatic test_single_fetch();
        logic [19:0] exp [8] = '{O_S18, O_S33, O_S33, O_S33L, O_S35, O_P1, O_P1, O_P1};
        run2 = 1'b1;  // held high throughout: ignored outside HALTED
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (o2 !== exp[i]) begin
                n_err++; $display("FAIL fetch[%0d] got %b want %b", i + 1, o2, exp[i]);
            end
        end
        run2 = 1'b0;
    endtask

    task automatic test_pause();
        logic [19:0] exp [11] = '{O_P2, O_P2, O_P2, O_S18, O_S33, O_S33, O_S33L, O_S35, O_P1, O_P1, O_P1};
        for (int i = 0; i < 11; i++) begin
            cont2 = (i < 3);
            tick();
            n_cmp++;
            if (o2 !== exp[i]) begin
                n_err++; $display("FAIL pause[%0d] got %b want %b", i, o2, exp[i]);
            end
        end
        cont2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Continue re-asserted during the fetch: PAUSE1 lasts one cycle, then wait in PAUSE2.
        logic [19:0] exp [15] = '{O_P2, O_S18, O_S33, O_S33, O_S33L, O_S35, O_P1, O_P2, O_P2,
                                  O_S18, O_S33, O_S33, O_S33L, O_S35, O_P1};
        logic        cseq [15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            cont2 = cseq[i];
            tick();
            n_cmp++;
            if (o2 !== exp[i]) begin
                n_err++; $display("FAIL b2b[%0d] got %b want %b", i, o2, exp[i]);
            end
        end
        cont2 = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic [19:0] exp [8] = '{O_P2, O_S18, O_S33, O_S33, O_HALT, O_HALT, O_HALT, O_HALT};
        logic        seen_ld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cont2 = (i == 0);
            rst2  = (i == 4);   // set while in the second S33 cycle
            tick();
            if (ld_mdr || ld_ir) seen_ld = 1'b1;
            n_cmp++;
            if (o2 !== exp[i]) begin
                n_err++; $display("FAIL rst_mid[%0d] got %b want %b", i, o2, exp[i]);
            end
        end
        rst2 = 1'b0;
        n_cmp++;
        if (seen_ld !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_loads got %b want 0", seen_ld);
        end
    endtask

    task automatic test_wait0();
        logic [19:0] exp [5] = '{O_S18, O_S33L, O_S35, O_P1, O_P1};
        run0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) run0 = 1'b0;
            n_cmp++;
            if (o0 !== exp[i]) begin
                n_err++; $display("FAIL wait0[%0d] got %b want %b", i + 1, o0, exp[i]);
            end
        end
    endtask

    task automatic test_bus_exclusive();
        int fetches = 0;
        int cyc     = 0;
        int gates;
        while (fetches < 5 && cyc < 2000) begin
            run2  = 1'($urandom_range(0, 1));
            cont2 = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            gates = int'(g_pc) + int'(g_mdr) + int'(g_alu) + int'(g_marmux);
            n_cmp++;
            if (gates > 1) begin
                n_err++; $display("FAIL bus_excl[%0d] got %0d gates want <=1", cyc, gates);
            end
            n_cmp++;
            if ({addr2mux, aluk} !== 4'b0000) begin
                n_err++; $display("FAIL mux_zero[%0d] got %b want 0000", cyc, {addr2mux, aluk});
            end
            if (ld_ir) fetches++;
        end
        run2 = 1'b0; cont2 = 1'b0;
        n_cmp++;
        if (fetches != 5) begin
            n_err++; $display("FAIL bus_fetches got %0d want 5 within budget", fetches);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        test_reset();
        test_single_fetch();
        test_pause();
        test_back_to_back();
        test_reset_mid_read();
        test_wait0();
        test_bus_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
# fetch_control

Fetch-phase control state machine that drives the LC-3 datapath's register-load, bus-gate and mux-select lines. It fetches one instruction per run step: PC to MAR, a multi-cycle memory read into MDR, then MDR to IR. It then pauses until the operator toggles Continue. It sits directly upstream of the datapath; every datapath control input comes from this block, and memory handshake lines go to the SRAM wrapper that supplies `MDR_In`.

## Interface
- `MEM_WAIT`, default 2: extra cycles the memory read is held before MDR is loaded. Legal range is 0–15.
- `Clk` input 1: system clock; all state changes on its rising edge.
- `Reset_ah` input 1: synchronous, active-high reset. It has priority over every other input.
- `Run` input 1: level. Starts a fetch when sampled high in `HALTED`.
- `Continue` input 1: level. Releases the pause after a fetch.
- `LD_PC`, `LD_IR`, `LD_MAR`, `LD_MDR` output 1 each: datapath register loads.
- `GatePC`, `GateMDR`, `GateALU`, `GateMARMUX` output 1 each: bus drivers. At most one is high in any cycle.
- `PCMUX` output 2: PC source select. `00` = bus, `01` = adder, `10` = PC+1.
- `ADDR2MUX`, `ALUK` output 2 each: held at `00` in this block.
- `Mem_OE` output 1: active-low memory output enable.
- `Mem_WE` output 1: active-low write enable. Constantly 1, because this block never writes.
- `State` output 4: current state encoding, for debug/hex display.

## Operation
- Moore machine. All outputs are decoded from the registered state plus the wait counter only. No input reaches an output combinationally.
- Outputs not listed for a state are low, except `Mem_OE`/`Mem_WE`, which are high, and `PCMUX`/`ADDR2MUX`/`ALUK`, which are `00`.
- `HALTED` (State=0)
  - No outputs asserted.
  - `Run`=1 → `S18`; otherwise stay.
- `S18` (State=1)
  - Asserts `GatePC`, `LD_MAR`, `LD_PC`, `PCMUX`=`10`.
  - Always → `S33`, and clears the wait counter to 0.
- `S33` (State=2)
  - `Mem_OE`=0 every cycle.
  - While the counter < `MEM_WAIT`: increment the counter and stay.
  - When the counter == `MEM_WAIT`: assert `LD_MDR` this cycle, then → `S35`.
- `S35` (State=3)
  - Asserts `GateMDR`, `LD_IR`.
  - Always → `PAUSE1`.
- `PAUSE1` (State=4)
  - No outputs asserted.
  - `Continue`=1 → `PAUSE2`; otherwise stay.
- `PAUSE2` (State=5)
  - No outputs asserted.
  - `Continue`=0 → `S18`; otherwise stay. A held `Continue` therefore produces exactly one further fetch.
- Unused encodings 6–15 → `HALTED` on the next edge, with outputs as in `HALTED`.
- Wait counter is 4 bits wide and never exceeds `MEM_WAIT`. It is only meaningful in `S33`.

## Timing
- Reset
  - `Reset_ah` high at an edge puts the machine in `HALTED` and the counter at 0.
  - This applies from any state, including mid-`S33`. The memory read is abandoned, `Mem_OE` returns high the cycle after the edge, and no `LD_MDR` or `LD_IR` is issued.
- Run and Continue
  - `Run` is ignored outside `HALTED`. After the first fetch the machine loops `PAUSE1`/`PAUSE2`/`S18` and never returns to `HALTED` except by reset.
  - `Run` and `Continue` are both ignored in `S18`, `S33` and `S35`.
- Fetch latency, counted from the edge that samples `Run`=1 in `HALTED` (cycle 0):
  - `S18` in cycle 1.
  - `S33` in cycles 2 .. 2+`MEM_WAIT`.
  - `S35` in cycle 3+`MEM_WAIT`.
  - `PAUSE1` in cycle 4+`MEM_WAIT`.
- `Mem_OE` is low for exactly `MEM_WAIT`+1 consecutive cycles per fetch. `LD_MDR` is high for exactly 1 cycle, the last of them.
- `LD_IR` is high for exactly 1 cycle per fetch, the cycle immediately after `LD_MDR`.
- Continue edge case: if `Continue` is already high on entry to `PAUSE1`, the machine goes to `PAUSE2` after one cycle and waits there for release.

## Test plan
- Reset then idle: `Reset_ah`=1 for 2 cycles, then `Run`=`Continue`=0 for 10 cycles → `State`=0 throughout, all loads and gates 0, `Mem_OE`=1, `Mem_WE`=1.
- Single fetch with `MEM_WAIT`=2: `Run`=1 at cycle 0 →
  - `State` sequence 1,2,2,2,3,4.
  - `GatePC`/`LD_MAR`/`LD_PC`/`PCMUX`=`10` only in cycle 1.
  - `Mem_OE`=0 in cycles 2–4; `LD_MDR`=1 only in cycle 4.
  - `GateMDR`/`LD_IR`=1 only in cycle 5.
- Pause handshake: from `PAUSE1`, `Continue`=1 for 3 cycles then 0 → `State` 4→5, stays 5 while `Continue` is high, then →1 exactly once. Only one fetch occurs.
- `MEM_WAIT`=0 variant: `Run`=1 → `S33` lasts 1 cycle with `Mem_OE`=0 and `LD_MDR`=1 in that same cycle, then `S35`.
- Reset mid-read (`MEM_WAIT`=2): assert `Reset_ah` in the second `S33` cycle → the next cycle has `State`=0 and `Mem_OE`=1. `LD_MDR` and `LD_IR` are never asserted.
- Bus exclusivity: over 5 consecutive fetches with random `Run`/`Continue` timing → the count of high Gate signals is ≤1 every cycle, and `ADDR2MUX`=`ALUK`=`00` always.
